// File: rtl/axi_mem_width_bridge.sv
// axi_mem_width_bridge: packs RATIO narrow AXI write beats into one wide
// memory word and unpacks wide memory read words into narrow AXI beats.
// Ports: cfg_* (write/read start address, read length, load/start strobes),
//   AXI_w* (write beat stream), AXI_r* (read beat stream),
//   MEM_* (single-port SRAM: ce/we/addr/wdata/rdata), rd_busy_o, rd_done_o.
// Option: define AXI_MEM_BRIDGE_PREFETCH_EN to add a second read buffer
//   that fetches the next word while the current one drains.
module axi_mem_width_bridge #(
   parameter int AXI_DATA_WIDTH   = 32,
   parameter int MEM_DATA_WIDTH   = 128,
   parameter int MEM_ADDR_WIDTH   = 10,
   parameter int MEM_READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [MEM_ADDR_WIDTH-1:0] cfg_waddr_i,
   input  logic [MEM_ADDR_WIDTH-1:0] cfg_raddr_i,
   input  logic [MEM_ADDR_WIDTH:0]   cfg_rlen_i,
   input  logic                      cfg_wload_i,
   input  logic                      cfg_rstart_i,
   input  logic                      AXI_wvalid_i,
   output logic                      AXI_wready_o,
   input  logic [AXI_DATA_WIDTH-1:0] AXI_wdata_i,
   input  logic                      AXI_wlast_i,
   output logic                      AXI_rvalid_o,
   input  logic                      AXI_rready_i,
   output logic [AXI_DATA_WIDTH-1:0] AXI_rdata_o,
   output logic                      AXI_rlast_o,
   output logic                      MEM_ce_o,
   output logic                      MEM_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] MEM_addr_o,
   output logic [MEM_DATA_WIDTH-1:0] MEM_wdata_o,
   input  logic [MEM_DATA_WIDTH-1:0] MEM_rdata_i,
   output logic                      rd_busy_o,
   output logic                      rd_done_o
);

   localparam int RATIO = MEM_DATA_WIDTH / AXI_DATA_WIDTH;
   localparam int LW = $clog2(RATIO);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
   localparam logic [1:0] LAT_END = 2'(MEM_READ_LATENCY - 1);

   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DRAIN} rstate_t;

   // ---------------- write packing ----------------
   logic [MEM_DATA_WIDTH-1:0] wbuf;
   logic [LW-1:0]             wlane;
   logic                      wpend;
   logic [MEM_ADDR_WIDTH-1:0] wptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbuf  <= '0;
         wlane <= '0;
         wpend <= 1'b0;
         wptr  <= '0;
      end else if (wpend) begin
         // the pending word goes out this cycle; no beat is accepted
         wpend <= 1'b0;
         wptr  <= wptr + 1'b1;
         wbuf  <= '0;
      end else begin
         if (cfg_wload_i)
            wptr <= cfg_waddr_i;
         if (AXI_wvalid_i) begin
            wbuf[wlane*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= AXI_wdata_i;
            if (wlane == LAST_LANE || AXI_wlast_i) begin
               wpend <= 1'b1;
               wlane <= '0;
            end else begin
               wlane <= wlane + 1'b1;
            end
         end
      end
   end

   // ---------------- read unpacking ----------------
   rstate_t                   state, state_n;
   logic [MEM_ADDR_WIDTH-1:0] rptr;
   logic [MEM_ADDR_WIDTH:0]   rem;
   logic [MEM_DATA_WIDTH-1:0] rbuf;
   logic [LW-1:0]             rlane;
   logic                      inflight;
   logic [1:0]                lat_cnt;
   logic                      done_q, done_n;
   logic                      start, cap, hs, last_hs, more, rd_iss, ld_mem;

`ifdef AXI_MEM_BRIDGE_PREFETCH_EN
   logic [MEM_DATA_WIDTH-1:0] pbuf;
   logic                      pf_full, pf_go, ld_pf, ld_pbuf;

   // fetch ahead only when nothing else is outstanding
   assign pf_go = (state == R_DRAIN) && (rem != '0) && !wpend
                  && !inflight && !pf_full;
   // words still owed: unissued, in flight, or parked in pbuf
   assign more = (rem != '0) || pf_full || inflight;
   assign rd_iss = ((state == R_ISSUE) && !wpend) || pf_go;
`else
   assign more = (rem != '0);
   assign rd_iss = (state == R_ISSUE) && !wpend;
`endif

   assign start = (state == R_IDLE) && cfg_rstart_i && (cfg_rlen_i != '0);
   // read data for the outstanding issue is on MEM_rdata_i this cycle
   assign cap = inflight && (lat_cnt == LAT_END);
   assign hs = (state == R_DRAIN) && AXI_rready_i;
   assign last_hs = hs && (rlane == LAST_LANE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= R_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      ld_mem  = 1'b0;
`ifdef AXI_MEM_BRIDGE_PREFETCH_EN
      ld_pf   = 1'b0;
      ld_pbuf = 1'b0;
`endif
      unique case (state)
         R_IDLE: begin
            if (start)
               state_n = R_ISSUE;
            else if (cfg_rstart_i)
               done_n = 1'b1;
         end
         R_ISSUE: begin
            if (!wpend)
               state_n = R_WAIT;
         end
         R_WAIT: begin
            if (cap) begin
               state_n = R_DRAIN;
               ld_mem  = 1'b1;
            end
         end
         R_DRAIN: begin
`ifdef AXI_MEM_BRIDGE_PREFETCH_EN
            if (cap && !last_hs)
               ld_pbuf = 1'b1;
            if (last_hs) begin
               if (pf_full)
                  ld_pf = 1'b1;
               else if (cap)
                  ld_mem = 1'b1;
               else if (inflight || pf_go)
                  state_n = R_WAIT;
               else if (rem != '0)
                  state_n = R_ISSUE;
               else begin
                  state_n = R_IDLE;
                  done_n  = 1'b1;
               end
            end
`else
            if (last_hs) begin
               if (more)
                  state_n = R_ISSUE;
               else begin
                  state_n = R_IDLE;
                  done_n  = 1'b1;
               end
            end
`endif
         end
         default: state_n = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr     <= '0;
         rem      <= '0;
         rbuf     <= '0;
         rlane    <= '0;
         inflight <= 1'b0;
         lat_cnt  <= '0;
         done_q   <= 1'b0;
`ifdef AXI_MEM_BRIDGE_PREFETCH_EN
         pbuf     <= '0;
         pf_full  <= 1'b0;
`endif
      end else begin
         done_q <= done_n;
         if (start) begin
            rptr <= cfg_raddr_i;
            rem  <= cfg_rlen_i;
         end
         if (rd_iss) begin
            rptr     <= rptr + 1'b1;
            rem      <= rem - 1'b1;
            inflight <= 1'b1;
            lat_cnt  <= '0;
         end else if (inflight) begin
            if (cap)
               inflight <= 1'b0;
            else
               lat_cnt <= lat_cnt + 1'b1;
         end
         if (ld_mem)
            rbuf <= MEM_rdata_i;
         if (hs)
            rlane <= rlane + 1'b1;
`ifdef AXI_MEM_BRIDGE_PREFETCH_EN
         if (ld_pbuf) begin
            pbuf    <= MEM_rdata_i;
            pf_full <= 1'b1;
         end
         if (ld_pf) begin
            rbuf    <= pbuf;
            pf_full <= 1'b0;
         end
`endif
      end
   end

   // ---------------- outputs ----------------
   assign AXI_wready_o = !wpend && !rst;
   assign AXI_rvalid_o = (state == R_DRAIN);
   assign AXI_rdata_o  = rbuf[rlane*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   assign AXI_rlast_o  = AXI_rvalid_o && !more && (rlane == LAST_LANE);
   // writes own the port whenever a word is pending
   assign MEM_ce_o     = wpend || rd_iss;
   assign MEM_we_o     = wpend;
   assign MEM_addr_o   = wpend ? wptr : (rd_iss ? rptr : '0);
   assign MEM_wdata_o  = wpend ? wbuf : '0;
   assign rd_busy_o    = (state != R_IDLE);
   assign rd_done_o    = done_q;

endmodule

// File: tb/tb_axi_mem_width_bridge.sv
// tb_axi_mem_width_bridge: directed bench for axi_mem_width_bridge with a
// behavioural SRAM (read latency 2) and a handshake monitor.
module tb_axi_mem_width_bridge;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [9:0]   waddr = '0, raddr = '0;
   logic [10:0]  rlen = '0;
   logic         wload = 1'b0, rstart = 1'b0;
   logic         wvalid = 1'b0, wlast = 1'b0, rready = 1'b0;
   logic [31:0]  wdata = '0;
   logic         wready, rvalid, rlast, ce, we, busy, done;
   logic [31:0]  rdata;
   logic [9:0]   addr;
   logic [127:0] mwdata, mrdata;

   axi_mem_width_bridge #(
      .AXI_DATA_WIDTH(32),
      .MEM_DATA_WIDTH(128),
      .MEM_ADDR_WIDTH(10),
      .MEM_READ_LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_waddr_i(waddr), .cfg_raddr_i(raddr), .cfg_rlen_i(rlen),
      .cfg_wload_i(wload), .cfg_rstart_i(rstart),
      .AXI_wvalid_i(wvalid), .AXI_wready_o(wready),
      .AXI_wdata_i(wdata), .AXI_wlast_i(wlast),
      .AXI_rvalid_o(rvalid), .AXI_rready_i(rready),
      .AXI_rdata_o(rdata), .AXI_rlast_o(rlast),
      .MEM_ce_o(ce), .MEM_we_o(we), .MEM_addr_o(addr),
      .MEM_wdata_o(mwdata), .MEM_rdata_i(mrdata),
      .rd_busy_o(busy), .rd_done_o(done)
   );

   always #5 clk = ~clk;

   // SRAM model, two-cycle read latency
   logic [127:0] mem [0:1023];
   logic [127:0] pipe0, pipe1;
   always @(posedge clk) begin
      if (ce && we) mem[addr] <= mwdata;
      pipe0 <= (ce && !we) ? mem[addr] : 'x;
      pipe1 <= pipe0;
   end
   assign mrdata = pipe1;

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // monitor
   int cyc = 0;
   int first_iss, first_rv, first_hs, last_hs_c, last_wr, done_c, n_iss;
   int n_ce = 0;
   bit done_seen, stall_prev;
   logic [31:0] stall_d;
   logic [31:0] rq[$];
   bit lq[$];
   logic [31:0] eq[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (ce) n_ce++;
      if (!rst) begin
         if (ce && !we) begin
            n_iss++;
            if (first_iss < 0) first_iss = cyc;
         end
         if (ce && we) last_wr = cyc;
         if (rvalid && first_rv < 0) first_rv = cyc;
         if (stall_prev) begin
            chk("hold_valid", rvalid, 1);
            chk("hold_data", rdata, stall_d);
         end
         stall_prev = rvalid && !rready;
         stall_d = rdata;
         if (rvalid && rready) begin
            rq.push_back(rdata);
            lq.push_back(rlast);
            if (first_hs < 0) first_hs = cyc;
            last_hs_c = cyc;
         end
         if (done) begin
            done_seen = 1;
            done_c = cyc;
         end
      end
   end

   task automatic clear_mon();
      first_iss = -1; first_rv = -1; first_hs = -1;
      last_hs_c = -1; last_wr = -1; done_c = -1; n_iss = 0;
      done_seen = 0; stall_prev = 0;
      rq.delete(); lq.delete(); eq.delete();
   endtask

   task automatic do_wload(input logic [9:0] a);
      waddr = a; wload = 1;
      @(posedge clk); #1;
      wload = 0;
   endtask

   task automatic wbeat(input logic [31:0] d, input bit last, output int n);
      n = 0;
      wvalid = 1; wdata = d; wlast = last;
      while (!wready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
      wvalid = 0; wlast = 0;
   endtask

   task automatic rd_wait(input bit tog);
      for (int i = 0; i < 300 && !done_seen; i++) begin
         rready = tog ? ~rready : 1'b1;
         @(posedge clk); #1;
      end
      if (!done_seen) chk("rd_timeout", 0, 1);
   endtask

   task automatic rd_start(input logic [9:0] a, input logic [10:0] n);
      raddr = a; rlen = n; rstart = 1;
      @(posedge clk); #1;
      rstart = 0;
   endtask

   task automatic chk_beats(input string tag);
      int nl, pl;
      nl = 0; pl = -1;
      chk({tag, "_n"}, rq.size(), eq.size());
      for (int i = 0; i < eq.size() && i < rq.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), rq[i], eq[i]);
      for (int i = 0; i < lq.size(); i++)
         if (lq[i]) begin nl++; if (pl < 0) pl = i; end
      chk({tag, "_rlast_n"}, nl, 1);
      chk({tag, "_rlast_pos"}, pl, eq.size() - 1);
   endtask

   int st[8];
   int sd;

   initial begin
      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wready", wready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_ce", ce, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      rst = 0;
      @(posedge clk); #1;

      // eight beats with wvalid held
      do_wload(10'h010);
      for (int i = 0; i < 8; i++) wbeat(i, 0, st[i]);
      repeat (3) @(posedge clk); #1;
      chk("mem010", mem[10'h010], 128'h00000003_00000002_00000001_00000000);
      chk("mem011", mem[10'h011], 128'h00000007_00000006_00000005_00000004);
      chk("wr_stall3", st[3], 0);
      chk("wr_stall4", st[4], 1);

      // partial word flushed by wlast, then lane 0 restart
      wbeat(32'hA, 0, sd);
      wbeat(32'hB, 0, sd);
      wbeat(32'hC, 1, sd);
      for (int i = 1; i <= 4; i++) wbeat(i, 0, sd);
      repeat (3) @(posedge clk); #1;
      chk("mem012", mem[10'h012], 128'h00000000_0000000C_0000000B_0000000A);
      chk("mem013", mem[10'h013], 128'h00000004_00000003_00000002_00000001);

      // pointer wrap
      do_wload(10'h3FF);
      for (int i = 0; i < 8; i++) wbeat(32'h10 + i, 0, sd);
      repeat (3) @(posedge clk); #1;
      chk("mem3ff", mem[10'h3FF], 128'h00000013_00000012_00000011_00000010);
      chk("mem000", mem[10'h000], 128'h00000017_00000016_00000015_00000014);

      // two-word read, rready held
      clear_mon();
      rready = 1;
      rd_start(10'h010, 11'd2);
      chk("rd_busy", busy, 1);
      rd_wait(0);
      for (int i = 0; i < 8; i++) eq.push_back(i);
      chk_beats("rd2");
      chk("rd2_lat", first_rv - first_iss, 3);
      chk("rd2_done", done_c - last_hs_c, 1);
      @(posedge clk); #1;
      chk("rd2_idle", busy, 0);

      // write pending while read issues; rready toggling
      clear_mon();
      do_wload(10'h020);
      for (int i = 1; i <= 3; i++) wbeat(32'h20 + i, 0, sd);
      wvalid = 1; wdata = 32'h24;
      raddr = 10'h020; rlen = 11'd1; rstart = 1;
      @(posedge clk); #1;
      wvalid = 0; rstart = 0; rready = 0;
      rd_wait(1);
      chk("mem020", mem[10'h020], 128'h00000024_00000023_00000022_00000021);
      chk("wr_first", first_iss - last_wr, 1);
      for (int i = 1; i <= 4; i++) eq.push_back(32'h20 + i);
      chk_beats("rdw");

      // zero-length read
      clear_mon();
      rready = 1;
      rd_start(10'h010, 11'd0);
      repeat (2) @(posedge clk); #1;
      chk("rlen0_done", done_seen, 1);
      chk("rlen0_iss", n_iss, 0);

      // reset mid-drain
      clear_mon();
      rready = 0;
      rd_start(10'h010, 11'd2);
      for (int i = 0; i < 20 && !rvalid; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_rv", rvalid, 1);
      #2 rst = 1;
      #1;
      chk("arst_rvalid", rvalid, 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_busy", busy, 0);
      chk("arst_wready", wready, 0);
      chk("arst_rlast", rlast, 0);
      sd = n_ce;
      repeat (3) @(posedge clk); #1;
      rst = 0;
      repeat (5) @(posedge clk); #1;
      chk("arst_no_ce", n_ce, sd);
      clear_mon();
      rready = 1;
      rd_start(10'h011, 11'd1);
      rd_wait(0);
      for (int i = 4; i < 8; i++) eq.push_back(i);
      chk_beats("post_rst");

      // four-word stream
      clear_mon();
      rready = 1;
      rd_start(10'h010, 11'd4);
      rd_wait(0);
      for (int i = 0; i < 8; i++) eq.push_back(i);
      eq.push_back(32'hA); eq.push_back(32'hB);
      eq.push_back(32'hC); eq.push_back(0);
      for (int i = 1; i <= 4; i++) eq.push_back(i);
      chk_beats("rd4");
`ifdef AXI_MEM_BRIDGE_PREFETCH_EN
      chk("rd4_nogap", last_hs_c - first_hs, 15);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
